led_panel_receiver: RTL

//  Receiving end of the 1-bit-RGB LED panel link: oversamples the 16-bit LED_PANEL
//  bus driven by the panel driver, rebuilds each shifted row and FM6126 init writes.

---
 rtl/led_panel_receiver.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/led_panel_receiver.sv
// Receiving end of the 1-bit-RGB LED panel link: oversamples LED_PANEL, rebuilds shifted rows
// and FM6126 init-register writes, and replays each committed row as a valid/ready column stream.
module led_panel_receiver #(
   parameter int unsigned COLS        = 64,
   parameter int unsigned ADDR_BITS   = 5,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [15:0]          LED_PANEL,
   output logic                 pix_valid,
   input  logic                 pix_ready,
   output logic [ADDR_BITS-1:0] pix_addr,
   output logic [5:0]           pix_col,
   output logic [5:0]           pix_rgb,
   output logic                 pix_last,
   output logic                 reg_valid,
   output logic                 reg_sel,
   output logic [15:0]          reg_data,
   output logic                 blank_level,
   output logic                 overrun,
   output logic                 proto_err
);
   localparam int unsigned EW = $clog2(COLS + 2);

   typedef enum logic {StShift, StLatch} shift_state_e;
   typedef enum logic [1:0] {StIdle, StAddr, StSend} stream_state_e;

   logic [SYNC_STAGES-1:0][15:0] sync_q;
   logic [15:0]                  s;
   logic                         sclk_d_q, latch_d_q;
   logic                         sclk_rise, latch_rise, latch_fall;
   logic [5:0]                   rgb_in;
   logic [4:0]                   addr_in;
   logic                         unused_bits;

   shift_state_e                 shift_state_q;
   logic [COLS-1:0][5:0]         shreg_q;
   logic [COLS-1:0][5:0]         rowbuf_q;
   logic [15:0]                  hist_q;
   logic [EW-1:0]                edge_cnt_q;
   logic [3:0]                   lcnt_q;
   logic                         commit_q;

   stream_state_e                stream_state_q;
   logic [5:0]                   col_nxt;

   // Edge and data both come from the last synchronizer stage, so they stay aligned.
   assign s          = sync_q[SYNC_STAGES-1];
   assign sclk_rise  = s[14] & ~sclk_d_q;
   assign latch_rise = s[13] & ~latch_d_q;
   assign latch_fall = ~s[13] & latch_d_q;
   assign rgb_in     = {s[4], s[5], s[6], s[0], s[1], s[2]};
   assign addr_in    = {s[15], s[11:8]};
   assign unused_bits = s[3] ^ s[7];
   assign col_nxt    = pix_col + 6'd1;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q      <= '0;
         sclk_d_q    <= 1'b0;
         latch_d_q   <= 1'b0;
         blank_level <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], LED_PANEL};
         sclk_d_q    <= s[14];
         latch_d_q   <= s[13];
         blank_level <= s[12];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         shift_state_q <= StShift;
         shreg_q       <= '0;
         rowbuf_q      <= '0;
         hist_q        <= '0;
         edge_cnt_q    <= '0;
         lcnt_q        <= '0;
         commit_q      <= 1'b0;
         reg_valid     <= 1'b0;
         reg_sel       <= 1'b0;
         reg_data      <= '0;
         overrun       <= 1'b0;
         proto_err     <= 1'b0;
      end else begin
         reg_valid <= 1'b0;
         commit_q  <= 1'b0;
         // Newest column enters at the top, so index 0 always holds the first one shifted.
         if (sclk_rise) begin
            shreg_q <= {rgb_in, shreg_q[COLS-1:1]};
            hist_q  <= {hist_q[14:0], s[2]};
            if (edge_cnt_q != EW'(COLS + 1)) edge_cnt_q <= edge_cnt_q + EW'(1);
         end
         unique case (shift_state_q)
            StShift: begin
               if (latch_rise) begin
                  shift_state_q <= StLatch;
                  lcnt_q        <= sclk_rise ? 4'd1 : 4'd0;
               end
            end
            StLatch: begin
               if (sclk_rise && lcnt_q != 4'd15) lcnt_q <= lcnt_q + 4'd1;
               if (latch_fall) begin
                  shift_state_q <= StShift;
                  edge_cnt_q    <= '0;
                  if (lcnt_q == 4'd0 && edge_cnt_q == EW'(COLS)) begin
                     if (stream_state_q == StIdle) begin
                        rowbuf_q <= shreg_q;
                        commit_q <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else if (lcnt_q == 4'd11 || lcnt_q == 4'd12) begin
                     reg_valid <= 1'b1;
                     reg_sel   <= (lcnt_q == 4'd12);
                     reg_data  <= hist_q;
                  end else begin
                     proto_err <= 1'b1;
                  end
               end
            end
            default: shift_state_q <= StShift;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stream_state_q <= StIdle;
         pix_valid      <= 1'b0;
         pix_addr       <= '0;
         pix_col        <= '0;
         pix_rgb        <= '0;
         pix_last       <= 1'b0;
      end else begin
         unique case (stream_state_q)
            StIdle: begin
               if (commit_q) stream_state_q <= StAddr;
            end
            // The driver moves the address with the latch fall, so it is settled by now.
            StAddr: begin
               pix_addr       <= ADDR_BITS'(addr_in);
               pix_col        <= '0;
               pix_rgb        <= rowbuf_q[0];
               pix_last       <= (COLS == 1);
               pix_valid      <= 1'b1;
               stream_state_q <= StSend;
            end
            StSend: begin
               if (pix_ready) begin
                  if (pix_last) begin
                     pix_valid      <= 1'b0;
                     pix_last       <= 1'b0;
                     stream_state_q <= StIdle;
                  end else begin
                     pix_col  <= col_nxt;
                     pix_rgb  <= rowbuf_q[col_nxt];
                     pix_last <= (col_nxt == 6'(COLS - 1));
                  end
               end
            end
            default: stream_state_q <= StIdle;
         endcase
      end
   end

endmodule
